// File: rtl/spe_ingress_fifo_if.sv
// Valid/ready packet link used on both sides of the SPE ingress FIFO.
// master drives valid/data, slave drives ready.
interface spe_ingress_fifo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/spe_ingress_fifo.sv
// SPE ingress stage: FWFT packet FIFO between the NoC router port and the SPE depacketizer.
// Optional destination-address filter enabled by defining SPE_ADDR_FILTER_EN.
module spe_ingress_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_MSB = 31,
    parameter int unsigned ADDR_LSB = 28,
    parameter logic [ADDR_MSB-ADDR_LSB:0] LOCAL_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spe_ingress_fifo_if.slave        in_if,
    spe_ingress_fifo_if.master       out_if,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               drop_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

`ifdef SPE_ADDR_FILTER_EN
    localparam logic FILTER_EN = 1'b1;
`else
    localparam logic FILTER_EN = 1'b0;
`endif

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_occ;
    logic [7:0]       r_drop;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_handshake;
    logic             w_addr_mismatch;
    logic             w_store;
    logic             w_drop;
    logic             w_pop;
    logic [OW-1:0]    w_occ_next;
    logic [7:0]       w_drop_next;

    // Ready depends only on registered occupancy: a pop while full does not admit a push.
    assign w_in_ready  = (r_occ != FULL_OCC);
    assign w_out_valid = (r_occ != '0);

    assign w_handshake     = in_if.valid && w_in_ready;
    assign w_addr_mismatch = (in_if.data[ADDR_MSB:ADDR_LSB] != LOCAL_ADDR);
    assign w_store         = w_handshake && !(FILTER_EN && w_addr_mismatch);
    assign w_drop          = w_handshake &&  (FILTER_EN && w_addr_mismatch);
    assign w_pop           = w_out_valid && out_if.ready;

    always_comb begin
        w_occ_next = r_occ;
        unique case ({w_store, w_pop})
            2'b10:   w_occ_next = r_occ + 1'b1;
            2'b01:   w_occ_next = r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_comb begin
        w_drop_next = r_drop;
        if (w_drop && (r_drop != '1)) begin
            w_drop_next = r_drop + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_drop   <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ  <= w_occ_next;
            r_drop <= w_drop_next;
        end
    end

    // Storage has no reset; stale words are hidden by gating out_data with occupancy.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= in_if.data;
        end
    end

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = w_out_valid;
    assign out_if.data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign occupancy    = r_occ;
    assign drop_count   = r_drop;

endmodule

// File: tb/tb_spe_ingress_fifo.sv
// Directed self-checking bench for spe_ingress_fifo (LOCAL_ADDR=4'h3, DEPTH=4).
module tb_spe_ingress_fifo;
    logic       clk;
    logic       rst_n;
    logic [2:0] occupancy;
    logic [7:0] drop_count;
    int         total;
    int         bad;

`ifdef SPE_ADDR_FILTER_EN
    localparam logic [31:0] TAG = 32'h3000_0000;
`else
    localparam logic [31:0] TAG = 32'h0000_0000;
`endif

    spe_ingress_fifo_if #(.WIDTH(32)) in_if ();
    spe_ingress_fifo_if #(.WIDTH(32)) out_if ();

    spe_ingress_fifo #(
        .WIDTH     (32),
        .DEPTH     (4),
        .ADDR_MSB  (31),
        .ADDR_LSB  (28),
        .LOCAL_ADDR(4'h3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_if     (in_if.slave),
        .out_if    (out_if.master),
        .occupancy (occupancy),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        step();
        step();
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL rst_ovalid: got %b want 0", out_if.valid); end
        total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL rst_iready: got %b want 1", in_if.ready); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
        total++; if (out_if.data !== 32'd0) begin bad++; $display("FAIL rst_odata: got %h want 0", out_if.data); end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            in_if.valid = 1'b1;
            in_if.data = TAG | (32'h11 * (i + 1));
            step();
        end
        in_if.valid = 1'b0;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL pre_rst_occ: got %0d want 3", occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL async_rst_occ: got %0d want 0", occupancy); end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL async_rst_ovalid: got %b want 0", out_if.valid); end
        total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL async_rst_iready: got %b want 1", in_if.ready); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL async_rst_drop: got %0d want 0", drop_count); end
        #1;
        rst_n = 1'b1;
        step();
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL post_rst_ovalid: got %b want 0", out_if.valid); end
        total++; if (out_if.data !== 32'd0) begin bad++; $display("FAIL post_rst_odata: got %h want 0", out_if.data); end
    endtask

    task automatic test_single();
        logic [31:0] pkt;
        pkt = TAG | 32'h0A5A_5A5A;
        in_if.valid = 1'b1;
        in_if.data = pkt;
        step();
        in_if.valid = 1'b0;
        in_if.data = 32'hDEAD_BEEF;
        total++; if (out_if.valid !== 1'b1) begin bad++; $display("FAIL single_ovalid: got %b want 1", out_if.valid); end
        total++; if (out_if.data !== pkt) begin bad++; $display("FAIL single_odata: got %h want %h", out_if.data, pkt); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_if.data !== pkt || out_if.valid !== 1'b1)
                begin bad++; $display("FAIL single_hold%0d: got %b/%h want 1/%h", i, out_if.valid, out_if.data, pkt); end
        end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL single_popped: got %b want 0", out_if.valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL single_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 4; k++) begin
            in_if.valid = 1'b1;
            in_if.data = TAG | 32'(k);
            step();
        end
        total++; if (in_if.ready !== 1'b0) begin bad++; $display("FAIL fill_full_iready: got %b want 0", in_if.ready); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ4: got %0d want 4", occupancy); end
        in_if.data = TAG | 32'd5;
        step();
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_stall_occ: got %0d want 4", occupancy); end
        total++; if (out_if.data !== (TAG | 32'd1)) begin bad++; $display("FAIL fill_head1: got %h want %h", out_if.data, TAG | 32'd1); end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL fill_pop_while_full: got %0d want 3", occupancy); end
        total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL fill_iready_back: got %b want 1", in_if.ready); end
        step();
        in_if.valid = 1'b0;
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_fifth_accepted: got %0d want 4", occupancy); end
        out_if.ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            total++; if (out_if.data !== (TAG | 32'(k)) || out_if.valid !== 1'b1)
                begin bad++; $display("FAIL fill_drain%0d: got %b/%h want 1/%h", k, out_if.valid, out_if.data, TAG | 32'(k)); end
            step();
        end
        out_if.ready = 1'b0;
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL fill_empty: got %b want 0", out_if.valid); end
    endtask

    task automatic test_concurrent();
        for (int k = 0; k < 2; k++) begin
            in_if.valid = 1'b1;
            in_if.data = TAG | (32'd100 + 32'(k));
            step();
        end
        out_if.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_if.data = TAG | (32'd102 + 32'(i));
            total++; if (out_if.data !== (TAG | (32'd100 + 32'(i))) || occupancy !== 3'd2)
                begin bad++; $display("FAIL conc%0d: got %h occ %0d want %h occ 2", i, out_if.data, occupancy, TAG | (32'd100 + 32'(i))); end
            step();
        end
        in_if.valid = 1'b0;
        for (int i = 20; i < 22; i++) begin
            total++; if (out_if.data !== (TAG | (32'd100 + 32'(i))))
                begin bad++; $display("FAIL conc_tail%0d: got %h want %h", i, out_if.data, TAG | (32'd100 + 32'(i))); end
            step();
        end
        out_if.ready = 1'b0;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL conc_final_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_filter();
        logic [31:0] pkts [3];
        pkts[0] = 32'h3000_0011;
        pkts[1] = 32'h5000_0022;
        pkts[2] = 32'h3000_0033;
        for (int k = 0; k < 3; k++) begin
            in_if.valid = 1'b1;
            in_if.data = pkts[k];
            step();
        end
        in_if.valid = 1'b0;
`ifdef SPE_ADDR_FILTER_EN
        total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL filt_occ: got %0d want 2", occupancy); end
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL filt_drop1: got %0d want 1", drop_count); end
        out_if.ready = 1'b1;
        total++; if (out_if.data !== 32'h3000_0011) begin bad++; $display("FAIL filt_out0: got %h want 30000011", out_if.data); end
        step();
        total++; if (out_if.data !== 32'h3000_0033) begin bad++; $display("FAIL filt_out1: got %h want 30000033", out_if.data); end
        step();
        out_if.ready = 1'b0;
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL filt_empty: got %b want 0", out_if.valid); end
        in_if.valid = 1'b1;
        in_if.data = 32'h5000_00AA;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 253) begin
                total++; if (drop_count !== 8'hFF) begin bad++; $display("FAIL filt_reach_ff: got %h want ff", drop_count); end
            end
        end
        in_if.valid = 1'b0;
        total++; if (drop_count !== 8'hFF) begin bad++; $display("FAIL filt_saturate: got %h want ff", drop_count); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL filt_no_store: got %0d want 0", occupancy); end
`else
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL nofilt_occ: got %0d want 3", occupancy); end
        out_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_if.data !== pkts[k]) begin bad++; $display("FAIL nofilt_out%0d: got %h want %h", k, out_if.data, pkts[k]); end
            step();
        end
        out_if.ready = 1'b0;
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL nofilt_drop: got %0d want 0", drop_count); end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL nofilt_empty: got %b want 0", out_if.valid); end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_fill();
        test_concurrent();
        test_filter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
